// File: rtl/data_mem_pkg.sv
// Shared definitions for the MIPS data memory: access-type encodings and default depth.
package data_mem_pkg;

  localparam logic [2:0] MEM_W  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_HU = 3'd2;
  localparam logic [2:0] MEM_B  = 3'd3;
  localparam logic [2:0] MEM_BU = 3'd4;

  localparam int unsigned DM_DEPTH = 3072;

  function automatic logic op_legal(logic [2:0] op);
    return op <= MEM_BU;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store port between the CPU datapath (master) and the data memory (slave).
interface data_mem_if;

  logic [31:0] PC;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        WE;
  logic [2:0]  Op;
  logic [31:0] RData;
  logic        AddrErr;
  logic        ErrSticky;
  logic        TraceValid;
  logic [31:0] TracePC;
  logic [31:0] TraceAddr;
  logic [31:0] TraceData;

  modport master (
    output PC, Addr, WData, WE, Op,
    input  RData, AddrErr, ErrSticky, TraceValid, TracePC, TraceAddr, TraceData
  );

  modport slave (
    input  PC, Addr, WData, WE, Op,
    output RData, AddrErr, ErrSticky, TraceValid, TracePC, TraceAddr, TraceData
  );

endinterface

// File: rtl/data_mem_lane_ctrl.sv
// Byte-lane steering for loads and stores: enables, replicated write data, read extension and
// alignment check for one access.
module data_mem_lane_ctrl
  import data_mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
    byte_sel = rword[7:0];
    case (lane)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
  end

  always_comb begin
    be        = 4'b0000;
    wdata_al  = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (op)
      MEM_W: begin
        misalign  = (lane != 2'd0);
        be        = 4'b1111;
        wdata_al  = wdata;
        rdata_ext = rword;
      end
      MEM_H, MEM_HU: begin
        misalign  = lane[0];
        be        = lane[1] ? 4'b1100 : 4'b0011;
        // Replicate so the selected lanes always see the right bits.
        wdata_al  = {2{wdata[15:0]}};
        rdata_ext = (op == MEM_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      MEM_B, MEM_BU: begin
        be        = 4'b0001 << lane;
        wdata_al  = {4{wdata[7:0]}};
        rdata_ext = (op == MEM_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Data memory for the single-cycle MIPS core: combinational loads, lane-merged stores on the
// clock edge, sticky error flag and a registered store trace record.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DM_DEPTH,
  parameter int unsigned AW    = 12
) (
  input logic        Clk,
  input logic        Reset,
  data_mem_if.slave  bus
);

  localparam logic [31:0] ByteLimit = 32'(DEPTH * 4);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_al;
  logic [31:0]   rdata_ext;
  logic          misalign;
  logic          addr_err;
  logic [31:0]   mask;
  logic [31:0]   merged;
  logic          commit;

  logic          err_sticky_q;
  logic          trace_valid_q;
  logic [31:0]   trace_pc_q;
  logic [31:0]   trace_addr_q;
  logic [31:0]   trace_data_q;

  assign idx = bus.Addr[AW+1:2];
  // Full 32-bit compare so high address bits can never alias into the array.
  assign in_range = (bus.Addr < ByteLimit);
  assign rword    = in_range ? mem[idx] : '0;

  data_mem_lane_ctrl u_lane_ctrl (
    .op        (bus.Op),
    .lane      (bus.Addr[1:0]),
    .rword     (rword),
    .wdata     (bus.WData),
    .be        (be),
    .wdata_al  (wdata_al),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign addr_err = misalign | ~in_range | ~op_legal(bus.Op);
  assign mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged   = (rword & ~mask) | (wdata_al & mask);
  assign commit   = bus.WE & ~addr_err;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      err_sticky_q  <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= commit;
      if (commit) begin
        mem[idx]     <= merged;
        trace_pc_q   <= bus.PC;
        trace_addr_q <= {bus.Addr[31:2], 2'b00};
        trace_data_q <= merged;
      end
      if (bus.WE && addr_err) begin
        err_sticky_q <= 1'b1;
      end
    end
  end

  assign bus.RData      = addr_err ? '0 : rdata_ext;
  assign bus.AddrErr    = addr_err;
  assign bus.ErrSticky  = err_sticky_q;
  assign bus.TraceValid = trace_valid_q;
  assign bus.TracePC    = trace_pc_q;
  assign bus.TraceAddr  = trace_addr_q;
  assign bus.TraceData  = trace_data_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios then random traffic against a
// word-array reference model.
module tb_data_mem;

  localparam int unsigned Depth = 3072;

  logic clk;
  logic rst;

  data_mem_if bus ();

  data_mem #(
    .DEPTH (Depth),
    .AW    (12)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  logic [31:0] model [Depth];
  logic        exp_tv;
  logic        exp_sticky;
  logic [31:0] exp_tpc, exp_taddr, exp_tdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic [2:0] op);
    if (op > 3'd4) return 1'b1;
    if (a >= Depth * 4) return 1'b1;
    if (op == 3'd0 && (a % 4) != 0) return 1'b1;
    if ((op == 3'd1 || op == 3'd2) && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] w;
    longint unsigned v;
    if (m_err(a, op)) return 32'h0;
    w = model[a / 4];
    case (op)
      3'd0: return w;
      3'd1, 3'd2: begin
        v = (longint'(w) >> ((a % 4) * 8)) & 64'hFFFF;
        if (op == 3'd1 && v >= 64'h8000) v = v + 64'hFFFF_0000;
        return 32'(v);
      end
      default: begin
        v = (longint'(w) >> ((a % 4) * 8)) & 64'hFF;
        if (op == 3'd3 && v >= 64'h80) v = v + 64'hFFFF_FF00;
        return 32'(v);
      end
    endcase
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] a, input logic [31:0] wd,
                                          input logic [2:0] op);
    int unsigned     nbytes;
    longint unsigned low, wmask, data;
    nbytes = (op == 3'd0) ? 4 : (op <= 3'd2) ? 2 : 1;
    low    = (64'd1 << (8 * nbytes)) - 1;
    wmask  = (low << ((a % 4) * 8)) & 64'hFFFF_FFFF;
    data   = ((longint'(wd) & low) << ((a % 4) * 8)) & 64'hFFFF_FFFF;
    return 32'((longint'(model[a / 4]) & ~wmask & 64'hFFFF_FFFF) | data);
  endfunction

  task automatic do_cycle(input logic r, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] wd, input logic we, input logic [2:0] op,
                          input logic chk_comb, output logic [31:0] rd);
    logic [31:0] nw;
    rst = r; bus.PC = pc; bus.Addr = a; bus.WData = wd; bus.WE = we; bus.Op = op;
    #1;
    rd = bus.RData;
    if (chk_comb) begin
      check("rdata", bus.RData, m_read(a, op));
      check("addr_err", {31'b0, bus.AddrErr}, {31'b0, m_err(a, op)});
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < Depth; i++) model[i] = 32'h0;
      exp_sticky = 1'b0; exp_tv = 1'b0;
      exp_tpc = 32'h0; exp_taddr = 32'h0; exp_tdata = 32'h0;
    end else if (we && m_err(a, op)) begin
      exp_sticky = 1'b1; exp_tv = 1'b0;
    end else if (we) begin
      nw = m_merge(a, wd, op);
      model[a / 4] = nw;
      exp_tv = 1'b1; exp_tpc = pc; exp_taddr = a & 32'hFFFF_FFFC; exp_tdata = nw;
    end else begin
      exp_tv = 1'b0;
    end
    #1;
    check("trace_valid", {31'b0, bus.TraceValid}, {31'b0, exp_tv});
    check("err_sticky", {31'b0, bus.ErrSticky}, {31'b0, exp_sticky});
    if (exp_tv || r) begin
      check("trace_pc", bus.TracePC, exp_tpc);
      check("trace_addr", bus.TraceAddr, exp_taddr);
      check("trace_data", bus.TraceData, exp_tdata);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [2:0]  op;
    exp_tv = 1'b0; exp_sticky = 1'b0;
    exp_tpc = '0; exp_taddr = '0; exp_tdata = '0;

    do_cycle(1, 0, 32'h10, 0, 1, 0, 0, rd);
    do_cycle(0, 0, 32'h10, 0, 0, 0, 1, rd);
    check("reset_load", rd, 32'h0);

    do_cycle(0, 32'h3000, 32'h8, 32'h12345678, 1, 0, 1, rd);
    check("sw_trace_data", bus.TraceData, 32'h12345678);
    check("sw_trace_pc", bus.TracePC, 32'h3000);
    do_cycle(0, 0, 32'h8, 0, 0, 0, 1, rd);
    check("lw_after_sw", rd, 32'h12345678);

    do_cycle(0, 32'h3004, 32'h9, 32'hFFFFFF80, 1, 3, 1, rd);
    check("sb_trace_data", bus.TraceData, 32'h12348078);
    do_cycle(0, 0, 32'h9, 0, 0, 3, 1, rd);
    check("lb_signed", rd, 32'hFFFFFF80);
    do_cycle(0, 0, 32'h9, 0, 0, 4, 1, rd);
    check("lbu", rd, 32'h00000080);

    do_cycle(0, 32'h3008, 32'hA, 32'h0000BEEF, 1, 1, 1, rd);
    check("sh_trace_data", bus.TraceData, 32'hBEEF8078);
    do_cycle(0, 0, 32'hA, 0, 0, 1, 1, rd);
    check("lh_signed", rd, 32'hFFFFBEEF);
    do_cycle(0, 0, 32'hA, 0, 0, 2, 1, rd);
    check("lhu", rd, 32'h0000BEEF);

    do_cycle(0, 32'h300C, 32'h6, 32'hDEADBEEF, 1, 0, 1, rd);
    check("misalign_sticky", {31'b0, bus.ErrSticky}, 32'h1);
    do_cycle(0, 32'h3010, 32'h3000, 32'hDEADBEEF, 1, 0, 1, rd);
    do_cycle(0, 32'h3014, 32'h4008, 32'hCAFEF00D, 1, 0, 1, rd);
    do_cycle(0, 0, 32'h8, 0, 0, 0, 1, rd);
    check("word_unchanged", rd, 32'hBEEF8078);
    check("sticky_held", {31'b0, bus.ErrSticky}, 32'h1);

    do_cycle(0, 32'h3100, 32'h0, 32'h11111111, 1, 0, 1, rd);
    do_cycle(0, 32'h3104, 32'h4, 32'h22222222, 1, 0, 1, rd);
    do_cycle(0, 32'h3108, 32'h8, 32'h33333333, 1, 0, 1, rd);
    check("b2b_last_addr", bus.TraceAddr, 32'h8);
    do_cycle(1, 32'h310C, 32'hC, 32'h44444444, 1, 0, 0, rd);
    for (int i = 0; i < 16; i++) do_cycle(0, 0, 32'(i * 4), 0, 0, 0, 1, rd);

    for (int n = 0; n < 800; n++) begin
      a  = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = (Depth * 4 - 8) + $urandom_range(0, 15);
      if ($urandom_range(0, 31) == 0) a = $urandom;
      op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_cycle(($urandom_range(0, 99) == 0), $urandom, a, $urandom,
               1'($urandom_range(0, 1)), op, 1, rd);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
